// File: rtl/host_bridge.sv
// Host memory-op port bridge: register space decode, memory port 0 forwarding, fixed-latency reads.
// Optional free-running cycle counter at offset 0x81 is enabled by defining HOST_BRIDGE_CYCLE_CNT_EN.
module host_bridge #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_ADDR_W = 13,
  parameter int RD_LATENCY = 2,
  parameter int NUM_CTRL   = 4,
  parameter int NUM_STAT   = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [1:0]                 i_mem_op,
  input  logic [ADDR_W-1:0]          i_mem_addr,
  input  logic [DATA_W-1:0]          i_mem_data,
  output logic [DATA_W-1:0]          o_mem_data,
  output logic                       o_mem_op_pending,
  output logic [1:0]                 o_mem_op,
  output logic [MEM_ADDR_W-1:0]      o_mem_addr,
  output logic [DATA_W-1:0]          o_mem_wdata,
  input  logic [DATA_W-1:0]          i_mem_rdata,
  output logic [NUM_CTRL*DATA_W-1:0] o_ctrl,
  input  logic [NUM_STAT-1:0]        i_stat,
  output logic                       o_err
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [1:0] OP_READ   = 2'd1;
  localparam logic [1:0] OP_WRITE  = 2'd2;
  localparam logic [3:0] LAT       = 4'(RD_LATENCY);
  localparam logic [7:0] STAT_BASE = 8'h40;
  localparam logic [7:0] REJ_OFF   = 8'h80;
  localparam logic [7:0] CYC_OFF   = 8'h81;

  state_t                     state, state_next;
  logic [3:0]                 cnt;
  logic [MEM_ADDR_W-1:0]      addr_lat;
  logic [NUM_CTRL*DATA_W-1:0] ctrl;
  logic [15:0]                rej;
  logic [DATA_W-1:0]          cyc;
  logic [DATA_W-1:0]          reg_rdata;
  logic [7:0]                 offset;
  logic is_reg, own, idle, mem_rd, mem_wr, reg_rd, reg_wr, reject;
  logic unused_addr;

  assign is_reg      = i_mem_addr[ADDR_W-1];
  assign offset      = i_mem_addr[7:0];
  assign own         = ctrl[0];
  assign idle        = (state == IDLE);
  assign mem_rd      = idle && !is_reg && !own && (i_mem_op == OP_READ);
  assign mem_wr      = idle && !is_reg && !own && (i_mem_op == OP_WRITE);
  assign reg_rd      = idle && is_reg && (i_mem_op == OP_READ);
  assign reg_wr      = idle && is_reg && (i_mem_op == OP_WRITE);
  assign reject      = idle && !is_reg && own && (i_mem_op == OP_READ || i_mem_op == OP_WRITE);
  assign unused_addr = ^i_mem_addr[ADDR_W-2:MEM_ADDR_W];
  assign o_ctrl      = ctrl;
  assign o_err       = |rej;

  always_comb begin
    reg_rdata = '0;
    for (int k = 0; k < NUM_CTRL; k++)
      if (offset == 8'(k)) reg_rdata = ctrl[k*DATA_W +: DATA_W];
    for (int k = 0; k < NUM_STAT; k++)
      if (offset == STAT_BASE + 8'(k)) reg_rdata = DATA_W'(i_stat[k]);
    if (offset == REJ_OFF) reg_rdata = DATA_W'(rej);
    if (offset == CYC_OFF) reg_rdata = cyc;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (mem_rd) state_next = WAIT;
      WAIT: if (cnt == 4'd1) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // In WAIT the latched address stays on the port so memory keeps serving the read.
  always_comb begin
    o_mem_op         = 2'd0;
    o_mem_addr       = '0;
    o_mem_wdata      = '0;
    o_mem_op_pending = (state == WAIT);
    if (state == WAIT) begin
      o_mem_addr = addr_lat;
    end else if (mem_rd) begin
      o_mem_op   = OP_READ;
      o_mem_addr = i_mem_addr[MEM_ADDR_W-1:0];
    end else if (mem_wr) begin
      o_mem_op    = OP_WRITE;
      o_mem_addr  = i_mem_addr[MEM_ADDR_W-1:0];
      o_mem_wdata = i_mem_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt        <= '0;
      addr_lat   <= '0;
      ctrl       <= '0;
      rej        <= '0;
      o_mem_data <= '0;
    end else if (state == WAIT) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) o_mem_data <= i_mem_rdata;
    end else begin
      if (mem_rd) begin
        addr_lat <= i_mem_addr[MEM_ADDR_W-1:0];
        cnt      <= LAT;
      end
      if (reg_rd) o_mem_data <= reg_rdata;
      if (reject && rej != 16'hFFFF) rej <= rej + 16'd1;
      if (reg_wr) begin
        for (int k = 0; k < NUM_CTRL; k++)
          if (offset == 8'(k)) ctrl[k*DATA_W +: DATA_W] <= i_mem_data;
        if (offset == REJ_OFF) rej <= '0;
      end
    end
  end

`ifdef HOST_BRIDGE_CYCLE_CNT_EN
  // A host write wins over the increment for that one edge.
  always_ff @(posedge i_clk) begin
    if (i_rst)                          cyc <= '0;
    else if (reg_wr && offset == CYC_OFF) cyc <= i_mem_data;
    else                                cyc <= cyc + DATA_W'(1);
  end
`else
  assign cyc = '0;
`endif

endmodule

// File: tb/tb_host_bridge.sv
// Self-checking bench for host_bridge: two instances (read latency 2 and 5) share host stimulus,
// each checked every cycle against a transaction-level model plus hand-computed literals.
module tb_host_bridge;

  localparam logic [1:0]  NOP = 2'd0, RD = 2'd1, WR = 2'd2;
  localparam logic [63:0] REG = 64'h8000_0000_0000_0000;
`ifdef HOST_BRIDGE_CYCLE_CNT_EN
  localparam bit CYC_EN = 1'b1;
`else
  localparam bit CYC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  op = NOP;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic [3:0]  stat = '0;

  logic [63:0]  mem_data [2];
  logic         pend     [2];
  logic [1:0]   mop      [2];
  logic [12:0]  maddr    [2];
  logic [63:0]  mwdata   [2];
  logic [63:0]  rdata    [2];
  logic [255:0] ctrl     [2];
  logic         err      [2];

  logic [63:0] mem [2][8192];

  bit          m_busy  [2];
  int          m_left  [2];
  logic [12:0] m_raddr [2];
  logic [63:0] m_data  [2];
  logic [63:0] m_ctrl  [2][4];
  logic [63:0] m_cyc   [2];
  int          m_rej   [2];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  assign rdata[0] = mem[0][maddr[0]];
  assign rdata[1] = mem[1][maddr[1]];

  host_bridge #(.RD_LATENCY(2)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_mem_op(op), .i_mem_addr(addr), .i_mem_data(wdata),
    .o_mem_data(mem_data[0]), .o_mem_op_pending(pend[0]), .o_mem_op(mop[0]),
    .o_mem_addr(maddr[0]), .o_mem_wdata(mwdata[0]), .i_mem_rdata(rdata[0]),
    .o_ctrl(ctrl[0]), .i_stat(stat), .o_err(err[0])
  );

  host_bridge #(.RD_LATENCY(5)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_mem_op(op), .i_mem_addr(addr), .i_mem_data(wdata),
    .o_mem_data(mem_data[1]), .o_mem_op_pending(pend[1]), .o_mem_op(mop[1]),
    .o_mem_addr(maddr[1]), .o_mem_wdata(mwdata[1]), .i_mem_rdata(rdata[1]),
    .o_ctrl(ctrl[1]), .i_stat(stat), .o_err(err[1])
  );

  function automatic int latOf(int i);
    return (i == 0) ? 2 : 5;
  endfunction

  // What a register read at this offset must return, straight from the register map.
  function automatic logic [63:0] regVal(int i, logic [7:0] off);
    if (off < 8'd4)                      return m_ctrl[i][off[1:0]];
    if (off >= 8'h40 && off < 8'h44)     return 64'(stat[off[1:0]]);
    if (off == 8'h80)                    return 64'(m_rej[i]);
    if (off == 8'h81)                    return m_cyc[i];
    return 64'h0;
  endfunction

  task automatic cmp(string name, logic [255:0] act, logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic modelStep(int i);
    logic [63:0] rv;
    logic [63:0] nxt_cyc;
    if (rst) begin
      m_busy[i] = 1'b0; m_left[i] = 0; m_raddr[i] = '0; m_data[i] = '0;
      m_rej[i] = 0; m_cyc[i] = '0;
      for (int k = 0; k < 4; k++) m_ctrl[i][k] = '0;
      return;
    end
    rv      = regVal(i, addr[7:0]);
    nxt_cyc = m_cyc[i] + 64'd1;
    if (m_busy[i]) begin
      m_left[i]--;
      if (m_left[i] == 0) begin
        m_data[i] = mem[i][m_raddr[i]];
        m_busy[i] = 1'b0;
      end
    end else if (addr[63]) begin
      if (op == RD) m_data[i] = rv;
      else if (op == WR) begin
        if (addr[7:0] < 8'd4)                  m_ctrl[i][addr[1:0]] = wdata;
        else if (addr[7:0] == 8'h80)           m_rej[i] = 0;
        else if (addr[7:0] == 8'h81 && CYC_EN) nxt_cyc = wdata;
      end
    end else if (op == RD || op == WR) begin
      if (m_ctrl[i][0][0]) begin
        if (m_rej[i] < 65535) m_rej[i]++;
      end else if (op == RD) begin
        m_busy[i]  = 1'b1;
        m_left[i]  = latOf(i);
        m_raddr[i] = addr[12:0];
      end else begin
        mem[i][addr[12:0]] <= wdata;
      end
    end
    m_cyc[i] = CYC_EN ? nxt_cyc : 64'h0;
  endtask

  always @(posedge clk) begin
    modelStep(0);
    modelStep(1);
  end

  task automatic checkOutput(int i);
    string p = $sformatf("i%0d ", i);
    if (m_busy[i]) begin
      cmp({p, "mem_op"}, 256'(mop[i]), 256'(NOP));
      cmp({p, "mem_addr"}, 256'(maddr[i]), 256'(m_raddr[i]));
    end else if (addr[63] || m_ctrl[i][0][0] || op == NOP || op == 2'd3) begin
      cmp({p, "mem_op"}, 256'(mop[i]), 256'(NOP));
      cmp({p, "mem_addr"}, 256'(maddr[i]), 256'(0));
      cmp({p, "mem_wdata"}, 256'(mwdata[i]), 256'(0));
    end else begin
      cmp({p, "mem_op"}, 256'(mop[i]), 256'(op));
      cmp({p, "mem_addr"}, 256'(maddr[i]), 256'(addr[12:0]));
      if (op == WR) cmp({p, "mem_wdata"}, 256'(mwdata[i]), 256'(wdata));
    end
    cmp({p, "pending"}, 256'(pend[i]), 256'(m_busy[i]));
    cmp({p, "mem_data"}, 256'(mem_data[i]), 256'(m_data[i]));
    cmp({p, "err"}, 256'(err[i]), 256'(m_rej[i] != 0));
    cmp({p, "ctrl"}, ctrl[i], {m_ctrl[i][3], m_ctrl[i][2], m_ctrl[i][1], m_ctrl[i][0]});
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (chk_en) begin
        checkOutput(0);
        checkOutput(1);
      end
    end
  end

  task automatic applyStimulus(logic r, logic [1:0] o, logic [63:0] a, logic [63:0] d);
    @(negedge clk);
    rst = r; op = o; addr = a; wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, NOP, 64'h0, 64'h0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 8192; k++) mem[i][k] = 64'hC0DE_0000_0000_0000 | 64'(k);

    applyStimulus(1'b1, NOP, 64'h0, 64'h0);
    applyStimulus(1'b1, NOP, 64'h0, 64'h0);
    chk_en = 1'b1;

    // Reset state and a register read of ctrl 0.
    applyStimulus(1'b0, RD, REG, 64'h0);
    cmp("reset mem_data", 256'(mem_data[0]), 256'(0));
    cmp("reset pending", 256'(pend[0]), 256'(0));
    cmp("reset ctrl", ctrl[0], 256'(0));
    cmp("reset err", 256'(err[0]), 256'(0));

    // Memory write forwarded combinationally, then latency-2 / latency-5 reads.
    applyStimulus(1'b0, WR, 64'd5, 64'h1234);
    cmp("wr mem_op", 256'(mop[0]), 256'(2));
    cmp("wr mem_addr", 256'(maddr[0]), 256'(5));
    cmp("wr mem_wdata", 256'(mwdata[0]), 256'(64'h1234));
    applyStimulus(1'b0, RD, 64'd5, 64'h0);
    cmp("rd pending E0", 256'(pend[0]), 256'(1));
    idleCycles(1);
    cmp("rd pending E1", 256'(pend[0]), 256'(1));
    idleCycles(1);
    cmp("rd pending E2", 256'(pend[0]), 256'(0));
    cmp("rd data lat2", 256'(mem_data[0]), 256'(64'h1234));
    cmp("rd pending lat5 E2", 256'(pend[1]), 256'(1));
    idleCycles(3);
    cmp("rd data lat5", 256'(mem_data[1]), 256'(64'h1234));
    cmp("rd pending lat5 E5", 256'(pend[1]), 256'(0));

    // Unwritten location returns its preset contents.
    applyStimulus(1'b0, RD, 64'd9, 64'h0);
    idleCycles(5);
    cmp("rd addr9", 256'(mem_data[0]), 256'(64'hC0DE_0000_0000_0009));

    // ICP ownership: memory ops rejected and counted.
    applyStimulus(1'b0, WR, REG, 64'd1);
    applyStimulus(1'b0, WR, 64'd7, 64'hBEEF);
    cmp("own mem_op", 256'(mop[0]), 256'(0));
    applyStimulus(1'b0, RD, 64'd7, 64'h0);
    cmp("own no pending", 256'(pend[0]), 256'(0));
    applyStimulus(1'b0, RD, REG | 64'h80, 64'h0);
    cmp("rej count", 256'(mem_data[0]), 256'(2));
    cmp("err set", 256'(err[0]), 256'(1));
    applyStimulus(1'b0, WR, REG | 64'h80, 64'h0);
    cmp("err cleared", 256'(err[0]), 256'(0));
    applyStimulus(1'b0, WR, REG, 64'd0);

    // Control register R/W, RO write ignored, status reads, unmapped read.
    applyStimulus(1'b0, WR, REG | 64'h2, 64'hDEAD);
    applyStimulus(1'b0, RD, REG | 64'h2, 64'h0);
    cmp("ctrl2 rd", 256'(mem_data[0]), 256'(64'hDEAD));
    stat = 4'b0100;
    applyStimulus(1'b0, WR, REG | 64'h42, 64'h0);
    applyStimulus(1'b0, RD, REG | 64'h42, 64'h0);
    cmp("stat 0x42", 256'(mem_data[0]), 256'(1));
    applyStimulus(1'b0, RD, REG | 64'h43, 64'h0);
    cmp("stat 0x43", 256'(mem_data[0]), 256'(0));
    applyStimulus(1'b0, RD, REG | 64'h2, 64'h0);
    applyStimulus(1'b0, RD, REG | 64'h50, 64'h0);
    cmp("unmapped 0x50", 256'(mem_data[0]), 256'(0));

    // Cycle counter: load 100, three idle edges, read captures 103 (or 0 when absent).
    applyStimulus(1'b0, WR, REG | 64'h81, 64'd100);
    idleCycles(3);
    applyStimulus(1'b0, RD, REG | 64'h81, 64'h0);
    cmp("cycle counter", 256'(mem_data[0]), 256'(CYC_EN ? 64'd103 : 64'd0));

    // Reset during the third WAIT cycle of the latency-5 read.
    applyStimulus(1'b0, RD, 64'd5, 64'h0);
    idleCycles(2);
    cmp("mid-wait pending", 256'(pend[1]), 256'(1));
    applyStimulus(1'b1, NOP, 64'h0, 64'h0);
    cmp("abort pending", 256'(pend[1]), 256'(0));
    cmp("abort mem_data", 256'(mem_data[1]), 256'(0));
    idleCycles(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/host_bridge.md
# host_bridge

Parametrised host-side bridge between the external host memory-op port and the on-chip memory and register space. It decodes register operations (address MSB set), arbitrates host access to memory port 0, and waits a configurable number of cycles on reads. It exposes a bank of control registers and status inputs through the register map. Host memory operations attempted while the ICP owns memory are rejected and counted. It sits in `top` between the host pins and the `mem`/`icp` muxing.

## Interface
- `ADDR_W`, 64: host address width; bit `ADDR_W-1` selects register space.
- `DATA_W`, 64: data width.
- `MEM_ADDR_W`, 13: memory word address width.
- `RD_LATENCY`, 2: cycles from read acceptance to data capture; legal range 1..15.
- `NUM_CTRL`, 4: control registers (1..64).
- `NUM_STAT`, 4: status inputs (1..64).
---
- `i_clk`  in  1  clock; one clock domain.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_mem_op`  in  2  host op: 0 NOP, 1 READ, 2 WRITE, 3 treated as NOP.
- `i_mem_addr`  in  ADDR_W  host address.
- `i_mem_data`  in  DATA_W  host write data.
- `o_mem_data`  out  DATA_W  host read data, registered.
- `o_mem_op_pending`  out  1  read in flight; host must hold all inputs stable while high.
- `o_mem_op`  out  2  memory port 0 op.
- `o_mem_addr`  out  MEM_ADDR_W  memory port 0 address.
- `o_mem_wdata`  out  DATA_W  memory port 0 write data.
- `i_mem_rdata`  in  DATA_W  memory port 0 read data.
- `o_ctrl`  out  NUM_CTRL*DATA_W  control registers, flattened; reg k occupies `[k*DATA_W +: DATA_W]`.
- `i_stat`  in  NUM_STAT  status bits, e.g. ICP halted.
- `o_err`  out  1  high when the reject counter is nonzero.

## Operation
- ICP ownership: `own = o_ctrl[0]` (ctrl reg 0, bit 0).
- Register map. A register op is `i_mem_addr[ADDR_W-1]=1`. Offset = `i_mem_addr[7:0]`; other bits are ignored.
  - 0x00..NUM_CTRL-1: control registers, R/W.
  - 0x40..0x40+NUM_STAT-1: `i_stat[k]` zero-extended, RO.
  - 0x80: reject counter, 16-bit, saturating at 0xFFFF, zero-extended. Any write clears it.
  - 0x81: cycle counter (see Configuration).
  - Unmapped reads return 0. Unmapped writes and RO writes are ignored.
- State machine:
  - IDLE: accepts ops.
  - WAIT: 4-bit counter `cnt`.
- In IDLE:
  - Register write: updates the register at the edge.
  - Register read: `o_mem_data` updates at the edge. No pending.
  - Memory op with `own=1`: not forwarded; reject counter +1.
  - Memory WRITE with `own=0`: `o_mem_op=2`, `o_mem_addr=i_mem_addr[MEM_ADDR_W-1:0]` and `o_mem_wdata=i_mem_data`, all combinational in the same cycle. No pending.
  - Memory READ with `own=0`: `o_mem_op=1` and address driven combinationally. At the edge, latch the address, set `cnt=RD_LATENCY`, go to WAIT.
- In WAIT:
  - `o_mem_op=0`; `o_mem_addr` = latched address; `cnt` decrements each edge.
  - When `cnt=1`: capture `i_mem_rdata` into `o_mem_data`, go to IDLE.
  - Host ops presented during WAIT are ignored (protocol violation).
- When `own=1` or the op is a register op: `o_mem_op=0`, `o_mem_addr=0`, `o_mem_wdata=0`.
- A write to ctrl 0 setting `own` while a read is in WAIT: the read still completes normally.

## Timing
- Reset values:
  - `o_mem_data=0`, `o_mem_op_pending=0`, `o_ctrl=0`, `o_err=0`.
  - Reject counter 0, cycle counter 0, state IDLE.
  - `o_mem_op=0`, `o_mem_addr=0`, `o_mem_wdata=0`.
- Read accepted at edge E0: `o_mem_op_pending` is high from E0 until edge E0+RD_LATENCY. At that edge `o_mem_data` holds the memory data and pending falls.
- Back-to-back reads: the next read can be accepted at the edge where pending falls +1 cycle (host sees pending low first).
- Register read/write and memory write: one cycle, no pending.
- Reset asserted mid-WAIT: aborts the read, returns to IDLE, pending low at the next edge, `o_mem_data` zeroed.
- Reject counter at 0xFFFF holds. A clear and a reject in the same cycle cannot occur (a single op per cycle).

## Configuration
- `HOST_BRIDGE_CYCLE_CNT_EN`:
  - Defined: a DATA_W-bit free-running cycle counter, reset 0, +1 every cycle, wraps. Readable at 0x81. A write loads the written value, and the increment resumes from it next cycle.
  - Undefined: no counter logic; 0x81 reads 0 and writes are ignored.

## Test plan
- Reset, then read 0x8000_0000_0000_0000 → `o_mem_data=0`; all outputs at reset values.
- Write 0x1234 to mem addr 5, then read addr 5 with RD_LATENCY=2 → pending high exactly 2 cycles; `o_mem_data=0x1234` at the falling edge of pending.
- Write 1 to ctrl 0, then host write to addr 7 → `o_mem_op` stays 0; reading 0x80 returns 1 and `o_err=1`. Write 0 to 0x80 → `o_err=0`.
- Drive `i_stat=4'b0100`, read offset 0x42 → 1; read offset 0x43 → 0; read 0x50 → 0.
- Start a read with RD_LATENCY=5 and assert `i_rst` on the 3rd WAIT cycle → pending low and `o_mem_data=0` after the next edge.
- With the macro defined, write 100 to 0x81, wait 3 cycles, then read → 103 (±1 for read-edge alignment, checked exactly against the bench model). With the macro undefined, reading 0x81 → 0.
